// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit CPU: word width, fetch FSM states and fetch defaults.
package cpu16_pkg;
  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] DEF_RESET_PC = 16'h0000;
  localparam logic [WORD_W-1:0] DEF_PC_STEP = 16'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } fetch_state_e;
endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry FIFO of {pc, instr} pairs; flush beats push, head reads zero when empty.
module fetch_queue
  import cpu16_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [WORD_W-1:0] push_pc_i,
  input  logic [WORD_W-1:0] push_instr_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [WORD_W-1:0] head_pc_o,
  output logic [WORD_W-1:0] head_instr_o
);
  logic [2*WORD_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*WORD_W-1:0] head;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PTR_W'(1);
      if (pop_i)  rd_d = rd_q + PTR_W'(1);
      if (push_i && !pop_i)      cnt_d = cnt_q + CNT_W'(1);
      else if (pop_i && !push_i) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by the count alone.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= {push_pc_i, push_instr_i};
  end

  assign head         = (cnt_q != '0) ? mem_q[rd_q] : '0;
  assign head_pc_o    = head[2*WORD_W-1:WORD_W];
  assign head_instr_o = head[WORD_W-1:0];
  assign count_o      = cnt_q;
endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns FetchPC, drives instruction memory and feeds decode via a small queue.
module fetch_controller
  import cpu16_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [WORD_W-1:0] PC_STEP  = DEF_PC_STEP,
  parameter int                DEPTH    = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  output logic [WORD_W-1:0] IM_Address,
  input  logic [WORD_W-1:0] IM_Instruction,
  input  logic              Redirect,
  input  logic [WORD_W-1:0] RedirectTarget,
  input  logic              Halt,
  output logic              Inst_Valid,
  input  logic              Inst_Ready,
  output logic [WORD_W-1:0] Inst_Data,
  output logic [WORD_W-1:0] Inst_PC,
  output logic              Halted
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  count;
  logic              push, pop, flush, full;

  assign full = (count == CNT_W'(DEPTH));
  assign pop  = Inst_Valid && Inst_Ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      ST_IDLE: if (Start) state_d = ST_RUN;
      ST_RUN: begin
        // Halt outranks Redirect; both discard whatever is buffered.
        if (Halt) begin
          state_d = ST_HALTED;
          flush   = 1'b1;
        end else if (Redirect) begin
          flush = 1'b1;
          pc_d  = RedirectTarget;
        end else if (!full || pop) begin
          push = 1'b1;
          pc_d = pc_q + PC_STEP;
        end
      end
      ST_HALTED: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (flush),
    .push_pc_i    (pc_q),
    .push_instr_i (IM_Instruction),
    .count_o      (count),
    .head_pc_o    (Inst_PC),
    .head_instr_o (Inst_Data)
  );

  assign IM_Address = pc_q;
  assign Inst_Valid = (count != '0);
  assign Halted     = (state_q == ST_HALTED);
endmodule

// File: tb/tb_fetch_controller.sv
// Directed and randomized bench for fetch_controller against a queue-based behavioural model.
module tb_fetch_controller;
  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [15:0] IM_Address;
  logic [15:0] IM_Instruction;
  logic        Redirect = 1'b0;
  logic [15:0] RedirectTarget = 16'h0000;
  logic        Halt = 1'b0;
  logic        Inst_Valid;
  logic        Inst_Ready = 1'b0;
  logic [15:0] Inst_Data;
  logic [15:0] Inst_PC;
  logic        Halted;

  int ncmp = 0;
  int nfail = 0;

  typedef struct { logic [15:0] pc; logic [15:0] ins; } ent_t;
  ent_t        mq[$];
  logic [15:0] mpc;
  int          mmode;  // 0 idle, 1 fetching, 2 halted
  logic [15:0] saved;

  function automatic logic [15:0] imem(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  assign IM_Instruction = imem(IM_Address);

  always #5 Clock = ~Clock;

  fetch_controller dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .Start          (Start),
    .IM_Address     (IM_Address),
    .IM_Instruction (IM_Instruction),
    .Redirect       (Redirect),
    .RedirectTarget (RedirectTarget),
    .Halt           (Halt),
    .Inst_Valid     (Inst_Valid),
    .Inst_Ready     (Inst_Ready),
    .Inst_Data      (Inst_Data),
    .Inst_PC        (Inst_PC),
    .Halted         (Halted)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply one clock edge's worth of behaviour to the model, using the inputs now driven.
  task automatic model_step();
    ent_t e;
    if (Reset) begin
      mmode = 0;
      mpc = 16'h0000;
      mq.delete();
    end else if (mmode == 0) begin
      if (Start) mmode = 1;
    end else if (mmode == 1) begin
      if (Halt) begin
        mmode = 2;
        mq.delete();
      end else if (Redirect) begin
        mq.delete();
        mpc = RedirectTarget;
      end else begin
        if (mq.size() > 0 && Inst_Ready) void'(mq.pop_front());
        if (mq.size() < 2) begin
          e.pc = mpc;
          e.ins = imem(mpc);
          mq.push_back(e);
          mpc = mpc + 16'd2;
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge Clock);
    model_step();
    #1;
    chk("im_address", IM_Address, mpc);
    chk("inst_valid", {15'd0, Inst_Valid}, {15'd0, mq.size() != 0});
    chk("inst_pc", Inst_PC, (mq.size() != 0) ? mq[0].pc : 16'h0000);
    chk("inst_data", Inst_Data, (mq.size() != 0) ? mq[0].ins : 16'h0000);
    chk("halted", {15'd0, Halted}, {15'd0, mmode == 2});
  endtask

  initial begin
    mq.delete();
    mpc = 16'h0000;
    mmode = 0;

    // Reset values
    Reset = 1'b1; cycle(); cycle();
    chk("rst_addr", IM_Address, 16'h0000);
    chk("rst_valid", {15'd0, Inst_Valid}, 16'd0);

    // Start with decode always ready: two-cycle latency then 0,2,4
    Reset = 1'b0; Start = 1'b1; Inst_Ready = 1'b1; cycle();
    Start = 1'b0;
    chk("start_lat_e0", {15'd0, Inst_Valid}, 16'd0);
    cycle(); chk("stream_pc0", Inst_PC, 16'h0000); chk("stream_v", {15'd0, Inst_Valid}, 16'd1);
    cycle(); chk("stream_pc2", Inst_PC, 16'h0002);
    cycle(); chk("stream_pc4", Inst_PC, 16'h0004);
    cycle(); chk("stream_pc6", Inst_PC, 16'h0006);

    // Back-pressure: queue fills, FetchPC stalls at 4, then drains without a gap
    Reset = 1'b1; cycle(); Reset = 1'b0;
    Inst_Ready = 1'b0; Start = 1'b1; cycle(); Start = 1'b0;
    repeat (5) cycle();
    chk("stall_addr", IM_Address, 16'h0004);
    chk("stall_head", Inst_PC, 16'h0000);
    Inst_Ready = 1'b1;
    cycle(); chk("drain_2", Inst_PC, 16'h0002);
    cycle(); chk("drain_4", Inst_PC, 16'h0004);

    // Redirect with a full queue: one bubble then 0x100, 0x102
    Inst_Ready = 1'b0; repeat (3) cycle();
    Redirect = 1'b1; RedirectTarget = 16'h0100; cycle();
    Redirect = 1'b0; Inst_Ready = 1'b1;
    chk("redir_bubble", {15'd0, Inst_Valid}, 16'd0);
    cycle(); chk("redir_pc0", Inst_PC, 16'h0100);
    cycle(); chk("redir_pc1", Inst_PC, 16'h0102);

    // Address wrap through 16'hFFFE
    Redirect = 1'b1; RedirectTarget = 16'hFFFC; cycle(); Redirect = 1'b0;
    cycle(); chk("wrap_fffc", Inst_PC, 16'hFFFC);
    cycle(); chk("wrap_fffe", Inst_PC, 16'hFFFE);
    cycle(); chk("wrap_0000", Inst_PC, 16'h0000);

    // Reset mid-stream with a full queue
    Inst_Ready = 1'b0; repeat (3) cycle();
    Reset = 1'b1; cycle(); Reset = 1'b0;
    chk("midrst_addr", IM_Address, 16'h0000);
    chk("midrst_valid", {15'd0, Inst_Valid}, 16'd0);
    chk("midrst_data", Inst_Data, 16'h0000);

    // Halt together with Redirect; Start afterwards is ignored
    Start = 1'b1; cycle(); Start = 1'b0; Inst_Ready = 1'b1;
    repeat (3) cycle();
    Halt = 1'b1; Redirect = 1'b1; RedirectTarget = 16'h0200; cycle();
    Halt = 1'b0; Redirect = 1'b0;
    chk("halt_flag", {15'd0, Halted}, 16'd1);
    chk("halt_valid", {15'd0, Inst_Valid}, 16'd0);
    saved = IM_Address;
    Start = 1'b1; repeat (3) cycle(); Start = 1'b0;
    chk("halt_addr_hold", IM_Address, saved);
    chk("halt_sticky", {15'd0, Halted}, 16'd1);

    // Randomized traffic
    Reset = 1'b1; cycle(); Reset = 1'b0;
    for (int i = 0; i < 600; i++) begin
      Reset          = ($urandom_range(0, 79) == 0);
      Start          = ($urandom_range(0, 3) == 0);
      Halt           = ($urandom_range(0, 59) == 0);
      Redirect       = ($urandom_range(0, 7) == 0);
      RedirectTarget = 16'($urandom_range(0, 32767)) << 1;
      Inst_Ready     = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences instruction fetch for the 16-bit CPU. Owns the fetch program counter, drives the address of the combinational instruction memory, and buffers fetched words in a small queue. Hands words to decode over a valid/ready handshake. Sits between the InstructionMemory and the decode stage; accepts branch/jump redirects from execute and halt from control.

## Interface
Parameters:
- RESET_PC, 16'h0000, fetch address after reset
- PC_STEP, 2, increment between sequential fetches (byte-addressed 16-bit words)
- DEPTH, 2, queue entries (power of two, ≥2)

Ports:
- Clock  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- Start  in  1  leave IDLE and begin fetching at RESET_PC
- IM_Address  out  16  address to InstructionMemory PC input
- IM_Instruction  in  16  combinational read data for IM_Address
- Redirect  in  1  taken branch/jump; flush and refetch
- RedirectTarget  in  16  new fetch address, valid with Redirect
- Halt  in  1  stop fetching, discard buffered words
- Inst_Valid  out  1  queue head holds a word for decode
- Inst_Ready  in  1  decode accepts head this cycle
- Inst_Data  out  16  head instruction word
- Inst_PC  out  16  address the head word was fetched from
- Halted  out  1  FSM in HALTED

## Operation
- FSM states: IDLE, RUN, HALTED. Encoding 2'b00/01/10.
- IDLE: no fetch; Start → RUN. Halt and Redirect ignored.
- RUN: Halt → HALTED (Halt wins over Redirect in the same cycle). Redirect → stay RUN with flush.
- HALTED: no fetch, queue empty, Halted=1. Leaves only via Reset. Start is ignored.
- FetchPC register drives IM_Address directly.
- Write condition in RUN, no Redirect, no Halt: count<DEPTH, or a pop in the same cycle. On write, push {FetchPC, IM_Instruction}. FetchPC ← FetchPC+PC_STEP, 16-bit wrap (16'hFFFE+2 → 16'h0000).
- Pop: Inst_Valid && Inst_Ready. Pop and push in the same cycle leave the count unchanged.
- Full, no pop: no write; FetchPC holds.
- Redirect: clear the queue (count←0). No write that cycle. FetchPC←RedirectTarget. A simultaneous pop is still a valid handoff to decode.
- Entering HALTED: clear the queue; FetchPC holds.
- Inst_Valid = (count≠0). Inst_Data/Inst_PC come from the head entry and read 0 when the queue is empty.

## Timing
- Reset values: state IDLE, FetchPC=IM_Address=RESET_PC, count 0, Inst_Valid 0, Inst_Data 0, Inst_PC 0, Halted 0.
- Start sampled at edge E0 → RUN after E0. First word written at E1. Inst_Valid=1 after E1 (2-cycle start latency).
- Steady state with Inst_Ready held high: one word per cycle, consecutive Inst_PC values differ by PC_STEP.
- Redirect at edge Er: Inst_Valid=0 after Er. Target word written at Er+1 and valid after Er+1 (one bubble).
- Halt at edge Eh: Halted=1 and Inst_Valid=0 after Eh.
- Reset mid-operation overrides everything: all reset values next cycle, queue contents discarded.
- Inst_Data/Inst_PC stable while Inst_Valid && !Inst_Ready.

## Structure
- Shared package cpu16_pkg holds WORD_W=16, the fetch FSM state typedef/localparams, and the default RESET_PC and PC_STEP.
- Sub-module fetch_queue: DEPTH-entry FIFO, 32-bit entries {pc, instr}, with push, pop, flush, count, head outputs. Flush has priority over push.
- fetch_controller holds the FSM, FetchPC and the write/redirect logic.

## Test plan
- Reset then Start, Inst_Ready=1, memory returns address-tagged words → Inst_PC 0,2,4,6 on consecutive cycles; first Inst_Valid two cycles after Start.
- Inst_Ready=0 for 5 cycles after start → count saturates at 2; IM_Address holds at 16'h0004; head stays PC 0. Releasing Ready drains 0,2,4 with no gap.
- Redirect to 16'h0100 while the queue holds 2 entries → Inst_Valid=0 next cycle; next word has Inst_PC=16'h0100, then 16'h0102.
- Halt and Redirect asserted together → Halted=1, Inst_Valid=0, no further IM_Address change; Start afterwards has no effect.
- Redirect to 16'hFFFC → Inst_PC sequence FFFC, FFFE, 0000.
- Reset asserted mid-stream with a full queue → next cycle all outputs at reset values and IM_Address=RESET_PC.
